// File: rtl/writeback_stage_if.sv
// Memory-to-writeback handshake bundle: valid/ready plus the retiring
// instruction's destination, ALU result or load address, and load type.
interface writeback_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_reg_write;
  logic        in_mem_to_reg;
  logic [4:0]  in_rd;
  logic [31:0] in_alu_result;
  logic [2:0]  in_load_type;

  modport master (
    output in_valid,
    input  in_ready,
    output in_reg_write,
    output in_mem_to_reg,
    output in_rd,
    output in_alu_result,
    output in_load_type
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_reg_write,
    input  in_mem_to_reg,
    input  in_rd,
    input  in_alu_result,
    input  in_load_type
  );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage; sole register-file writer. Ports: clk, rst (sync,
// active-high), in_if (slave handshake from memory stage), mem_rvalid /
// mem_rdata (load data), write_enable / write_register / busW (regfile
// write pulse), err_timeout / err_align (sticky), retired (count).
module writeback_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  writeback_stage_if.slave in_if,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        write_enable,
  output logic [4:0]  write_register,
  output logic [31:0] busW,
  output logic        err_timeout,
  output logic        err_align,
  output logic [31:0] retired
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_MEM = 1'b1;

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LH  = 3'd1;
  localparam logic [2:0] LT_LHU = 3'd2;
  localparam logic [2:0] LT_LB  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [0:0] state;
  logic [7:0] cnt;
  logic [4:0] ld_rd;
  logic [2:0] ld_type;
  logic [1:0] ld_off;
  logic       ld_wr;

  logic [1:0]  in_off;
  logic        in_half;
  logic        in_byte;
  logic        misalign;
  logic        in_wr;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign in_if.in_ready = (state != WAIT_MEM);

  assign in_off  = in_if.in_alu_result[1:0];
  assign in_half = (in_if.in_load_type == LT_LH) ||
                   (in_if.in_load_type == LT_LHU);
  assign in_byte = (in_if.in_load_type == LT_LB) ||
                   (in_if.in_load_type == LT_LBU);

  // Unknown load types behave as LW, so they need word alignment.
  always_comb begin
    misalign = 1'b0;
    if (in_half)
      misalign = in_off[0];
    else if (!in_byte)
      misalign = (in_off != 2'd0);
  end

  // Writes to r0 are dropped but the instruction still retires.
  assign in_wr = in_if.in_reg_write && (in_if.in_rd != 5'd0);

  // Big-endian: offset 0 is the most significant byte.
  always_comb begin
    ld_byte = mem_rdata[31:24];
    unique case (ld_off)
      2'd0: ld_byte = mem_rdata[31:24];
      2'd1: ld_byte = mem_rdata[23:16];
      2'd2: ld_byte = mem_rdata[15:8];
      2'd3: ld_byte = mem_rdata[7:0];
    endcase
  end

  assign ld_half = ld_off[1] ? mem_rdata[15:0] : mem_rdata[31:16];

  always_comb begin
    ld_data = mem_rdata;
    case (ld_type)
      LT_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      LT_LHU:  ld_data = {16'd0, ld_half};
      LT_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      LT_LBU:  ld_data = {24'd0, ld_byte};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= 8'd0;
      ld_rd          <= 5'd0;
      ld_type        <= LT_LW;
      ld_off         <= 2'd0;
      ld_wr          <= 1'b0;
      write_enable   <= 1'b0;
      write_register <= 5'd0;
      busW           <= 32'd0;
      err_timeout    <= 1'b0;
      err_align      <= 1'b0;
      retired        <= 32'd0;
    end else begin
      write_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (in_if.in_valid) begin
            if (!in_if.in_mem_to_reg) begin
              if (in_wr) begin
                write_enable   <= 1'b1;
                write_register <= in_if.in_rd;
                busW           <= in_if.in_alu_result;
              end
              retired <= retired + 32'd1;
            end else if (misalign) begin
              err_align <= 1'b1;
              retired   <= retired + 32'd1;
            end else begin
              ld_rd   <= in_if.in_rd;
              ld_type <= in_if.in_load_type;
              ld_off  <= in_off;
              ld_wr   <= in_wr;
              cnt     <= 8'd0;
              state   <= WAIT_MEM;
            end
          end
        end
        WAIT_MEM: begin
          // Data arriving in the final allowed cycle still wins.
          if (mem_rvalid) begin
            if (ld_wr) begin
              write_enable   <= 1'b1;
              write_register <= ld_rd;
              busW           <= ld_data;
            end
            retired <= retired + 32'd1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
            if (cnt == CNT_LAST) begin
              err_timeout <= 1'b1;
              retired     <= retired + 32'd1;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
